// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants for the button front-end: clock rate, default debounce and
// hold times, the helper that turns milliseconds into clock cycles, and the
// channel indices used by btn_conditioner.
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;
    localparam int unsigned HOLD_MS     = 1000;

    // Channel indices into the per-channel vectors of the conditioner.
    localparam int unsigned BTN_START  = 0;
    localparam int unsigned BTN_MODE   = 1;
    localparam int unsigned BTN_RETURN = 2;
    localparam int unsigned NUM_BTN    = 3;

    // Milliseconds to clock cycles at CLK_HZ.
    function automatic int unsigned cyc_from_ms(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the raw pad inputs and the conditioned outputs of btn_conditioner.
//   btn_start_raw, sw_mode_raw, btn_return_raw : raw asynchronous pads
//   bt_st        : one-cycle pulse on a debounced start press
//   btn_mode_sel : debounced mode-select level (1 = classic, 0 = infinity)
//   btn_return   : one-cycle pulse on an accepted return press
// Modports:
//   master : board / pad side, drives the raw pads and observes the outputs
//   slave  : the conditioner, reads the pads and drives the outputs
// -----------------------------------------------------------------------------
interface btn_conditioner_if;

    logic btn_start_raw;
    logic sw_mode_raw;
    logic btn_return_raw;
    logic bt_st;
    logic btn_mode_sel;
    logic btn_return;

    modport master (
        output btn_start_raw, sw_mode_raw, btn_return_raw,
        input  bt_st, btn_mode_sel, btn_return
    );

    modport slave (
        input  btn_start_raw, sw_mode_raw, btn_return_raw,
        output bt_st, btn_mode_sel, btn_return
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchroniser, debounce counter with stable level,
// and a registered rising-edge detector.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : raw asynchronous pad input
//   level : debounced stable level (accepted 2 + DEBOUNCE_CYC cycles after a
//           clean pad edge)
//   rise  : one-cycle pulse, one cycle after level rises
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = cyc_from_ms(DEBOUNCE_MS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             q;
    logic             q_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: every register here uses non-blocking assignment so that all flops
    // sample the values from before the edge; with blocking assignment the
    // two synchroniser stages would collapse into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYC consecutive samples differ
    // from q; any sample equal to q restarts the count, so partial counts
    // never accumulate across bounces. Clearing on accept keeps cnt below
    // DEBOUNCE_CYC, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (sync2 == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered press detector: releases and held levels give no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_d  <= 1'b0;
            rise <= 1'b0;
        end else begin
            q_d  <= q;
            rise <= q & ~q_d;
        end
    end

    assign level = q;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Front-end for the raw board buttons feeding the game mode FSM. Each channel
// is synchronised and debounced by a btn_debounce instance; this level maps
// the channels onto the FSM inputs.
// Ports:
//   clk   : system clock, 100 MHz
//   rst_n : asynchronous active-low reset
//   bus   : btn_conditioner_if.slave (raw pads in; bt_st, btn_mode_sel,
//           btn_return out)
// Configuration:
//   BTN_LONG_RETURN_EN : when defined, btn_return pulses once after the return
//   channel has been held for HOLD_CYC cycles; otherwise btn_return is a plain
//   press pulse like bt_st.
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = cyc_from_ms(DEBOUNCE_MS),
    parameter int unsigned HOLD_CYC     = cyc_from_ms(HOLD_MS)
) (
    input  logic                clk,
    input  logic                rst_n,
    btn_conditioner_if.slave    bus
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic               mode_sel_q;
    logic               return_pulse;

    assign raw[BTN_START]  = bus.btn_start_raw;
    assign raw[BTN_MODE]   = bus.sw_mode_raw;
    assign raw[BTN_RETURN] = bus.btn_return_raw;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

    // Mode select is a level; registering it matches the one-cycle lag of the
    // press pulses on the other two channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sel_q <= 1'b0;
        end else begin
            mode_sel_q <= level[BTN_MODE];
        end
    end

`ifdef BTN_LONG_RETURN_EN
    localparam int unsigned      HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_q;
    logic              unused_chan;

    // hold_cnt parks at HOLD_MAX until release, so a single hold produces
    // exactly one pulse; the pulse fires on the cycle the count reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= level[BTN_RETURN] && (hold_cnt == HOLD_MAX - 1'b1);
            if (!level[BTN_RETURN]) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign return_pulse = long_q;
    assign unused_chan  = ^{level[BTN_START], rise[BTN_MODE], rise[BTN_RETURN]};
`else
    localparam int unsigned unused_hold_cyc = HOLD_CYC;
    logic unused_chan;

    assign return_pulse = rise[BTN_RETURN];
    assign unused_chan  = ^{level[BTN_START], rise[BTN_MODE], level[BTN_RETURN]};
`endif

    assign bus.bt_st        = rise[BTN_START];
    assign bus.btn_mode_sel = mode_sel_q;
    assign bus.btn_return   = return_pulse;

endmodule
